// File: rtl/buzz_arbiter.sv
// ---------------------------------------------------------------------------
// buzz_arbiter
//   Arbitrates the shared answer-input path between two players during a
//   question round. It detects fresh button presses, grants one player at a
//   time, times the answer window, and locks a player out for a fixed time
//   after a wrong or late answer. It emits one-cycle score/penalty pulses for
//   the HP logic.
//
// Ports
//   CLK        system clock
//   RST_N      asynchronous active-low reset
//   ROUND_EN   high while a question round is live; low returns to IDLE
//   BUZZ[1:0]  synchronised button levels, bit i = player i
//   DONE_IN    one-cycle pulse: the granted player's answer has been judged
//   RESULT_OK  qualified by DONE_IN, 1 = correct, 0 = wrong
//   GRANT[1:0] one-hot (or zero) owner of the input path
//   BUSY       high while an answer window is running
//   LOCK[1:0]  bit i high while player i is locked out
//   TIMEOUT    one-cycle pulse when the answer window expires
//   WIN_P[1:0] one-cycle pulse, player i answered correctly
//   PEN_P[1:0] one-cycle pulse, player i answered wrong or timed out
//   PRIO       player index that wins a simultaneous buzz
// ---------------------------------------------------------------------------
module buzz_arbiter #(
  parameter int ANS_CYC  = 250_000_000,
  parameter int LOCK_CYC = 50_000_000,
  parameter int CW       = 28
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ROUND_EN,
  input  logic [1:0] BUZZ,
  input  logic       DONE_IN,
  input  logic       RESULT_OK,
  output logic [1:0] GRANT,
  output logic       BUSY,
  output logic [1:0] LOCK,
  output logic       TIMEOUT,
  output logic [1:0] WIN_P,
  output logic [1:0] PEN_P,
  output logic       PRIO
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_ANSWER = 2'd2,
    ST_CLOSED = 2'd3
  } state_t;

  localparam logic [CW-1:0] ANS_LAST  = CW'(ANS_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYC - 1);

  state_t        state_r;
  logic [1:0]    buzz_d_r;
  logic [1:0]    grant_r;
  logic          busy_r;
  logic [1:0]    lock_r;
  logic          timeout_r;
  logic [1:0]    win_r;
  logic [1:0]    pen_r;
  logic          prio_r;
  logic [CW-1:0] ans_cnt_r;
  logic [CW-1:0] lock_cnt_r [2];

  logic [1:0]    rise_s;
  logic [1:0]    pick_s;
  logic          ans_last_s;
  logic [1:0]    lock_start_s;

  // Fresh presses only: a held button or a press made while locked never requests.
  always_comb begin
    rise_s     = BUZZ & ~buzz_d_r & ~lock_r;
    ans_last_s = (ans_cnt_r == ANS_LAST);
    if (rise_s == 2'b11) begin
      pick_s = prio_r ? 2'b10 : 2'b01;
    end else begin
      pick_s = rise_s;
    end
  end

  // Lockout starts for the owner on a wrong answer or an expiry without DONE_IN.
  always_comb begin
    lock_start_s = 2'b00;
    if (ROUND_EN && (state_r == ST_ANSWER) &&
        ((DONE_IN && !RESULT_OK) || (!DONE_IN && ans_last_s))) begin
      lock_start_s = grant_r;
    end else begin
      lock_start_s = 2'b00;
    end
  end

  // Main round FSM with registered grant, busy, priority and result pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      buzz_d_r  <= 2'b00;
      grant_r   <= 2'b00;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
      win_r     <= 2'b00;
      pen_r     <= 2'b00;
      prio_r    <= 1'b0;
      ans_cnt_r <= '0;
    end else begin
      buzz_d_r  <= BUZZ;
      timeout_r <= 1'b0;
      win_r     <= 2'b00;
      pen_r     <= 2'b00;
      if (!ROUND_EN) begin
        // Leaving the round beats any judge result arriving on the same edge.
        state_r   <= ST_IDLE;
        grant_r   <= 2'b00;
        busy_r    <= 1'b0;
        ans_cnt_r <= '0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r   <= ST_OPEN;
            grant_r   <= 2'b00;
            busy_r    <= 1'b0;
            ans_cnt_r <= '0;
          end
          ST_OPEN: begin
            if (rise_s != 2'b00) begin
              state_r   <= ST_ANSWER;
              grant_r   <= pick_s;
              busy_r    <= 1'b1;
              ans_cnt_r <= '0;
              // Next simultaneous buzz favours whoever was not granted now.
              prio_r    <= ~pick_s[1];
            end else begin
              state_r <= ST_OPEN;
            end
          end
          ST_ANSWER: begin
            if (DONE_IN) begin
              // A judge result on the expiry cycle takes precedence over TIMEOUT.
              if (RESULT_OK) begin
                win_r   <= grant_r;
                state_r <= ST_CLOSED;
              end else begin
                pen_r   <= grant_r;
                state_r <= ST_OPEN;
              end
              grant_r <= 2'b00;
              busy_r  <= 1'b0;
            end else if (ans_last_s) begin
              timeout_r <= 1'b1;
              pen_r     <= grant_r;
              grant_r   <= 2'b00;
              busy_r    <= 1'b0;
              state_r   <= ST_OPEN;
            end else begin
              ans_cnt_r <= ans_cnt_r + CW'(1);
            end
          end
          ST_CLOSED: begin
            grant_r <= 2'b00;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r   <= ST_IDLE;
            grant_r   <= 2'b00;
            busy_r    <= 1'b0;
            ans_cnt_r <= '0;
          end
        endcase
      end
    end
  end

  // Per-player lockout timers; LOCK stays high for exactly LOCK_CYC cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_r        <= 2'b00;
      lock_cnt_r[0] <= '0;
      lock_cnt_r[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!ROUND_EN) begin
          lock_r[i]     <= 1'b0;
          lock_cnt_r[i] <= '0;
        end else if (lock_start_s[i]) begin
          lock_r[i]     <= 1'b1;
          lock_cnt_r[i] <= '0;
        end else if (lock_r[i]) begin
          // The counter parks at its terminal value once the lock drops.
          if (lock_cnt_r[i] == LOCK_LAST) begin
            lock_r[i] <= 1'b0;
          end else begin
            lock_cnt_r[i] <= lock_cnt_r[i] + CW'(1);
          end
        end else begin
          lock_r[i] <= 1'b0;
        end
      end
    end
  end

  assign GRANT   = grant_r;
  assign BUSY    = busy_r;
  assign LOCK    = lock_r;
  assign TIMEOUT = timeout_r;
  assign WIN_P   = win_r;
  assign PEN_P   = pen_r;
  assign PRIO    = prio_r;

endmodule

// File: tb/tb_buzz_arbiter.sv
// ---------------------------------------------------------------------------
// tb_buzz_arbiter
//   Self-checking bench for buzz_arbiter with ANS_CYC=20, LOCK_CYC=8.
//   A hand-derived vector table covers the basic grant/penalty/lock/priority
//   flow, short hand sequences cover expiry, DONE_IN on the expiry cycle and
//   asynchronous reset, and a random phase is compared every cycle against a
//   behavioural model that tracks owner, elapsed window and remaining lock time.
// ---------------------------------------------------------------------------
module tb_buzz_arbiter;

  localparam int ANS_CYC  = 20;
  localparam int LOCK_CYC = 8;
  localparam int CW       = 28;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       ROUND_EN;
  logic [1:0] BUZZ;
  logic       DONE_IN;
  logic       RESULT_OK;
  logic [1:0] GRANT;
  logic       BUSY;
  logic [1:0] LOCK;
  logic       TIMEOUT;
  logic [1:0] WIN_P;
  logic [1:0] PEN_P;
  logic       PRIO;

  int n_checks = 0;
  int n_fail   = 0;

  buzz_arbiter #(.ANS_CYC(ANS_CYC), .LOCK_CYC(LOCK_CYC), .CW(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .ROUND_EN(ROUND_EN), .BUZZ(BUZZ),
    .DONE_IN(DONE_IN), .RESULT_OK(RESULT_OK), .GRANT(GRANT), .BUSY(BUSY),
    .LOCK(LOCK), .TIMEOUT(TIMEOUT), .WIN_P(WIN_P), .PEN_P(PEN_P), .PRIO(PRIO)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  int         m_phase;        // 0 idle, 1 open, 2 answer, 3 closed
  int         m_owner;        // -1 when nobody holds the path
  int         m_used;         // answer-window cycles already shown to the owner
  int         m_lock_left [2];
  int         m_prio;
  logic [1:0] m_prev;
  logic [1:0] m_win;
  logic [1:0] m_pen;
  logic       m_to;

  task automatic model_reset();
    m_phase = 0; m_owner = -1; m_used = 0;
    m_lock_left[0] = 0; m_lock_left[1] = 0;
    m_prio = 0; m_prev = 2'b00; m_win = 2'b00; m_pen = 2'b00; m_to = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic [1:0] b, input logic d, input logic ok);
    logic [1:0] press;
    int cand;
    m_win = 2'b00; m_pen = 2'b00; m_to = 1'b0;
    for (int i = 0; i < 2; i++) press[i] = b[i] && !m_prev[i] && (m_lock_left[i] == 0);
    for (int i = 0; i < 2; i++) if (m_lock_left[i] > 0) m_lock_left[i]--;
    if (!r) begin
      m_phase = 0; m_owner = -1; m_used = 0;
      m_lock_left[0] = 0; m_lock_left[1] = 0;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: begin
          cand = -1;
          if (press == 2'b11) cand = m_prio;
          else if (press[0]) cand = 0;
          else if (press[1]) cand = 1;
          if (cand >= 0) begin
            m_owner = cand; m_used = 1; m_phase = 2; m_prio = 1 - cand;
          end
        end
        2: begin
          if (d) begin
            if (ok) begin m_win[m_owner] = 1'b1; m_phase = 3; end
            else begin
              m_pen[m_owner] = 1'b1; m_lock_left[m_owner] = LOCK_CYC; m_phase = 1;
            end
            m_owner = -1;
          end else if (m_used == ANS_CYC) begin
            m_to = 1'b1; m_pen[m_owner] = 1'b1; m_lock_left[m_owner] = LOCK_CYC;
            m_phase = 1; m_owner = -1;
          end else begin
            m_used++;
          end
        end
        default: ;
      endcase
    end
    m_prev = b;
  endtask

  function automatic logic [10:0] model_out();
    logic [1:0] g;
    logic [1:0] lk;
    g = 2'b00;
    if (m_owner == 0) g = 2'b01;
    else if (m_owner == 1) g = 2'b10;
    lk = {m_lock_left[1] > 0, m_lock_left[0] > 0};
    return {g, m_phase == 2, lk, m_to, m_win, m_pen, m_prio[0]};
  endfunction

  function automatic logic [10:0] dut_out();
    return {GRANT, BUSY, LOCK, TIMEOUT, WIN_P, PEN_P, PRIO};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge CLK);
    model_edge(ROUND_EN, BUZZ, DONE_IN, RESULT_OK);
    #1;
    check("model", 16'(dut_out()), 16'(model_out()));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       r;
    logic [1:0] b;
    logic       d;
    logic       ok;
    logic [10:0] exp;   // {GRANT,BUSY,LOCK,TIMEOUT,WIN_P,PEN_P,PRIO}
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic r, input logic [1:0] b, input logic d, input logic ok,
                              input logic [1:0] g, input logic bz, input logic [1:0] lk,
                              input logic to, input logic [1:0] w, input logic [1:0] p,
                              input logic pr);
    vec_t v;
    v.r = r; v.b = b; v.d = d; v.ok = ok;
    v.exp = {g, bz, lk, to, w, p, pr};
    return v;
  endfunction

  initial begin
    //            r  b     d  ok   grant bsy lock  to  win   pen   prio
    tbl[0]  = mk(1, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0); // IDLE -> OPEN
    tbl[1]  = mk(1, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0);
    tbl[2]  = mk(1, 2'b01, 0, 0,  2'b01, 1, 2'b00, 0, 2'b00, 2'b00, 1); // p0 grant
    tbl[3]  = mk(1, 2'b01, 1, 0,  2'b00, 0, 2'b01, 0, 2'b00, 2'b01, 1); // wrong: pen, lock 1
    tbl[4]  = mk(1, 2'b00, 0, 0,  2'b00, 0, 2'b01, 0, 2'b00, 2'b00, 1); // lock 2
    tbl[5]  = mk(1, 2'b01, 0, 0,  2'b00, 0, 2'b01, 0, 2'b00, 2'b00, 1); // locked press dropped, lock 3
    tbl[6]  = mk(1, 2'b10, 0, 0,  2'b10, 1, 2'b01, 0, 2'b00, 2'b00, 0); // p1 grant, lock 4
    tbl[7]  = mk(1, 2'b10, 1, 1,  2'b00, 0, 2'b01, 0, 2'b10, 2'b00, 0); // win p1, lock 5
    tbl[8]  = mk(1, 2'b11, 0, 0,  2'b00, 0, 2'b01, 0, 2'b00, 2'b00, 0); // lock 6
    tbl[9]  = mk(1, 2'b00, 0, 0,  2'b00, 0, 2'b01, 0, 2'b00, 2'b00, 0); // lock 7
    tbl[10] = mk(1, 2'b00, 0, 0,  2'b00, 0, 2'b01, 0, 2'b00, 2'b00, 0); // lock 8
    tbl[11] = mk(1, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0); // lock released
    tbl[12] = mk(1, 2'b01, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0); // CLOSED ignores press
    tbl[13] = mk(0, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0); // IDLE
    tbl[14] = mk(1, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0); // OPEN
    tbl[15] = mk(1, 2'b11, 0, 0,  2'b01, 1, 2'b00, 0, 2'b00, 2'b00, 1); // tie, PRIO=0 wins
    tbl[16] = mk(1, 2'b11, 1, 1,  2'b00, 0, 2'b00, 0, 2'b01, 2'b00, 1); // win p0
    tbl[17] = mk(0, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 1); // IDLE
    tbl[18] = mk(1, 2'b00, 0, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 1); // OPEN
    tbl[19] = mk(1, 2'b11, 0, 0,  2'b10, 1, 2'b00, 0, 2'b00, 2'b00, 0); // tie, PRIO=1 wins
    tbl[20] = mk(0, 2'b11, 1, 0,  2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0); // drop beats DONE_IN

    RST_N = 1'b0; ROUND_EN = 1'b0; BUZZ = 2'b00; DONE_IN = 1'b0; RESULT_OK = 1'b0;
    model_reset();
    #7;
    check("reset_state", 16'(dut_out()), 16'(11'b0));
    RST_N = 1'b1;

    for (int i = 0; i < 21; i++) begin
      ROUND_EN = tbl[i].r; BUZZ = tbl[i].b; DONE_IN = tbl[i].d; RESULT_OK = tbl[i].ok;
      step();
      check($sformatf("vec%0d", i), 16'(dut_out()), 16'(tbl[i].exp));
    end

    // Timeout: player 1 holds the window for ANS_CYC cycles without DONE_IN.
    ROUND_EN = 1'b1; BUZZ = 2'b00; DONE_IN = 1'b0; RESULT_OK = 1'b0;
    step();
    BUZZ = 2'b10;
    step();
    check("to_grant", 16'({GRANT, BUSY}), 16'(3'b101));
    repeat (ANS_CYC - 1) step();
    check("to_before", 16'({GRANT, TIMEOUT}), 16'(3'b100));
    step();
    check("to_fire", 16'({GRANT, TIMEOUT, PEN_P, LOCK}), 16'({2'b00, 1'b1, 2'b10, 2'b10}));
    step();
    check("to_width", 16'({TIMEOUT, PEN_P, LOCK}), 16'({1'b0, 2'b00, 2'b10}));

    // DONE_IN correct on the expiry cycle: win, no timeout, round closed.
    ROUND_EN = 1'b0; BUZZ = 2'b00;
    step();
    check("drop_clear", 16'({GRANT, LOCK}), 16'(4'b0000));
    ROUND_EN = 1'b1;
    step();
    BUZZ = 2'b10;
    step();
    repeat (ANS_CYC - 1) step();
    DONE_IN = 1'b1; RESULT_OK = 1'b1;
    step();
    DONE_IN = 1'b0; RESULT_OK = 1'b0;
    check("win_at_expiry", 16'({WIN_P, TIMEOUT, PEN_P, GRANT, LOCK}),
          16'({2'b10, 1'b0, 2'b00, 2'b00, 2'b00}));
    BUZZ = 2'b00;
    step();
    BUZZ = 2'b01;
    step();
    check("closed_ignores", 16'({GRANT, BUSY}), 16'(3'b000));
    ROUND_EN = 1'b0; BUZZ = 2'b00;
    step();

    // Asynchronous reset in the middle of a lockout.
    ROUND_EN = 1'b1;
    step();
    BUZZ = 2'b01;
    step();
    DONE_IN = 1'b1; RESULT_OK = 1'b0;
    step();
    DONE_IN = 1'b0;
    check("lock_started", 16'({LOCK, PEN_P}), 16'(4'b0101));
    repeat (3) step();
    RST_N = 1'b0;
    #1;
    check("rst_async", 16'(dut_out()), 16'(11'b0));
    model_reset();
    #2;
    RST_N = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      ROUND_EN  = ($urandom_range(0, 79) != 0);
      BUZZ      = 2'($urandom_range(0, 3));
      DONE_IN   = ($urandom_range(0, 19) == 0);
      RESULT_OK = 1'($urandom_range(0, 1));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buzz_arbiter.md
Name: buzz_arbiter

Overview:
- Arbitrates the shared answer-input path between two players during a question round.
- Detects buzz-in presses and grants exactly one player at a time.
- Times the granted answer window and locks out a player after a wrong or late answer.
- Sits between the player buttons and the input/judge datapath; the top-level game controller enables it only while a question is live.
- Emits per-player score/penalty pulses consumed by the HP logic.

Parameters:
- ANS_CYC, 250_000_000, answer window length in CLK cycles (5 s at 50 MHz).
- LOCK_CYC, 50_000_000, per-player lockout length in CLK cycles after a wrong answer or timeout.
- CW, 28, width of the answer and lockout counters; must hold max(ANS_CYC, LOCK_CYC).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- ROUND_EN  in  1  high while a question round is live; low forces IDLE.
- BUZZ  in  2  synchronised button levels; bit i is player i.
- DONE_IN  in  1  one-cycle pulse from the judge: the granted player's answer is evaluated.
- RESULT_OK  in  1  qualified by DONE_IN; 1 = correct, 0 = wrong.
- GRANT  out  2  one-hot (or zero); the granted player owns the input path.
- BUSY  out  1  high in ANSWER.
- LOCK  out  2  bit i high while player i is locked out.
- TIMEOUT  out  1  one-cycle pulse when the answer window expires.
- WIN_P  out  2  one-cycle pulse on bit i when player i answered correctly.
- PEN_P  out  2  one-cycle pulse on bit i when player i answered wrong or timed out.
- PRIO  out  1  player index that wins a simultaneous buzz.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State IDLE.
  - GRANT, LOCK, TIMEOUT, WIN_P, PEN_P and BUSY = 0.
  - PRIO = 0; all counters = 0; buzz-edge registers = 0.
- Reset asserted mid-ANSWER: output clears immediately and no pulse is emitted.
- Edge detection:
  - BUZZ is registered into buzz_d.
  - rise[i] = BUZZ[i] & ~buzz_d[i] & ~LOCK[i].
  - A held button never re-requests. A press made while locked is discarded, not queued.
- States: IDLE, OPEN, ANSWER, CLOSED.
  - IDLE: all outputs low. ROUND_EN=1 -> OPEN on the next edge. LOCK cleared.
  - OPEN, on a rise:
    - One rise bit set -> that player is granted.
    - Both rise bits set -> player PRIO is granted.
    - Move to ANSWER. GRANT and BUSY are high in the cycle after the edge where the rise is sampled (1-cycle latency).
    - PRIO is set to the non-granted player on every grant (round-robin).
  - ANSWER:
    - ans_cnt increments from 0 each cycle.
    - DONE_IN & RESULT_OK -> WIN_P[g] pulse, GRANT cleared -> CLOSED.
    - DONE_IN & ~RESULT_OK -> PEN_P[g] pulse, start lockout g, GRANT cleared -> OPEN.
    - ans_cnt == ANS_CYC-1 with no DONE_IN -> TIMEOUT and PEN_P[g] pulse, start lockout g -> OPEN.
    - DONE_IN in the same cycle as expiry: DONE_IN wins and TIMEOUT is not asserted.
    - BUZZ activity from either player is ignored.
  - CLOSED: GRANT=0. Stays until ROUND_EN=0.
  - From any state, ROUND_EN=0 -> IDLE next edge.
    - GRANT, LOCK and counters are cleared; no pulses are generated.
    - ROUND_EN falling on the same edge as DONE_IN: the return to IDLE wins and no pulse is emitted.
- Lockout:
  - An independent counter per player is loaded on lockout start.
  - LOCK[i] is high for exactly LOCK_CYC cycles starting the cycle after the wrong/timeout edge, then drops.
  - Both players may be locked at once; OPEN then waits.
  - A lockout expiring while in OPEN makes that player eligible on the following cycle. A button still held does not count; a fresh rising edge is required.
- Output pulses (WIN_P, PEN_P, TIMEOUT) are registered, exactly 1 cycle wide, with at most one bit of WIN_P|PEN_P set.
- Counters saturate at their terminal value; they never wrap.

Test Plan:
All scenarios use ANS_CYC=20, LOCK_CYC=8.
- Reset then ROUND_EN=1, BUZZ=01 at cycle 5 -> GRANT=01 and BUSY=1 from cycle 6; PRIO becomes 1.
- In OPEN with PRIO=0, BUZZ=11 on the same edge -> GRANT=01 and PRIO=1. Next round, BUZZ=11 -> GRANT=10.
- Player 0 granted, DONE_IN=1 with RESULT_OK=0 -> PEN_P=01 for 1 cycle, LOCK=01 for exactly 8 cycles. Player 0 re-press during the lock is ignored; a player 1 press during the lock is granted.
- Player 1 granted, no DONE_IN for 20 cycles -> TIMEOUT=1 and PEN_P=10 on cycle 20, LOCK=10 follows.
- Repeat the timeout case but with DONE_IN=1 and RESULT_OK=1 on cycle 20 -> WIN_P=10, TIMEOUT=0, state CLOSED; further BUZZ is ignored until ROUND_EN=0.
- ROUND_EN dropped mid-ANSWER, and separately RST_N pulsed low mid-lockout -> GRANT=00 and LOCK=00 immediately (reset) or next edge (ROUND_EN), with no pulses emitted.
